// File: rtl/charlieplex_scanner_if.sv
// Bundle between a frame source and the charlieplex scanner: bitmap and global enable in,
// LED index, drive enable and frame strobe out.
interface charlieplex_scanner_if #(
  parameter int unsigned PINCOUNT = 4
);
  localparam int unsigned LEDCOUNT  = PINCOUNT * (PINCOUNT - 1);
  localparam int unsigned INDEXBITS = $clog2(LEDCOUNT);

  logic [LEDCOUNT-1:0]  leds;
  logic                 enable;
  logic [INDEXBITS-1:0] led_index;
  logic                 led_enable;
  logic                 frame_done;

  modport master (
    output leds,
    output enable,
    input  led_index,
    input  led_enable,
    input  frame_done
  );

  modport slave (
    input  leds,
    input  enable,
    output led_index,
    output led_enable,
    output frame_done
  );
endinterface

// File: rtl/charlieplex_scanner.sv
// Time-multiplexed charlieplex scanner: blank gap then dwell per LED slot, bitmap latched per frame.
// Define CHARLIEPLEX_SKIP_DARK_EN to collapse dark slots to a single blank cycle.
module charlieplex_scanner #(
  parameter int unsigned PINCOUNT     = 4,
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input logic                  clk,
  input logic                  rst,
  charlieplex_scanner_if.slave bus
);
  localparam int unsigned LEDCOUNT  = PINCOUNT * (PINCOUNT - 1);
  localparam int unsigned INDEXBITS = $clog2(LEDCOUNT);
  localparam int unsigned CntMax    = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CntW      = $clog2(CntMax + 1);

  localparam logic [CntW-1:0]      BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [CntW-1:0]      DwellLast = CntW'(DWELL_CYCLES - 1);
  localparam logic [INDEXBITS-1:0] IdxLast   = INDEXBITS'(LEDCOUNT - 1);

`ifdef CHARLIEPLEX_SKIP_DARK_EN
  localparam bit SkipDark = 1'b1;
`else
  localparam bit SkipDark = 1'b0;
`endif

  typedef enum logic {StBlank, StOn} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [INDEXBITS-1:0] idx_q, idx_d;
  logic [LEDCOUNT-1:0]  buf_q, buf_d;
  logic                 en_q, en_d;
  logic                 fd_q, fd_d;
  logic                 slot_lit;
  logic                 advance;

  assign slot_lit = buf_q[idx_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    en_d    = 1'b0;
    fd_d    = 1'b0;
    advance = 1'b0;

    unique case (state_q)
      StBlank: begin
        if (SkipDark && !slot_lit) begin
          advance = 1'b1;
        end else if (cnt_q == BlankLast) begin
          state_d = StOn;
          cnt_d   = '0;
          en_d    = bus.enable && slot_lit;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StOn: begin
        if (cnt_q == DwellLast) begin
          advance = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          en_d  = bus.enable && slot_lit;
        end
      end
    endcase

    // Slot change; wrapping to index 0 snapshots the next frame's bitmap.
    if (advance) begin
      state_d = StBlank;
      cnt_d   = '0;
      if (idx_q == IdxLast) begin
        idx_d = '0;
        buf_d = bus.leds;
        fd_d  = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StBlank;
      cnt_q   <= '0;
      idx_q   <= '0;
      buf_q   <= bus.leds;
      en_q    <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      en_q    <= en_d;
      fd_q    <= fd_d;
    end
  end

  assign bus.led_index  = idx_q;
  assign bus.led_enable = en_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_charlieplex_scanner.sv
// Bench for charlieplex_scanner (PINCOUNT=3, DWELL=4, BLANK=2): slot-level model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_charlieplex_scanner;
  localparam int unsigned Pins  = 3;
  localparam int unsigned Leds  = 6;
  localparam int unsigned Dwell = 4;
  localparam int unsigned Blank = 2;
  localparam int unsigned Slot  = Blank + Dwell;

`ifdef CHARLIEPLEX_SKIP_DARK_EN
  localparam bit SkipMode = 1'b1;
`else
  localparam bit SkipMode = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   t   = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  charlieplex_scanner_if #(.PINCOUNT(Pins)) sif ();

  charlieplex_scanner #(
    .PINCOUNT    (Pins),
    .DWELL_CYCLES(Dwell),
    .BLANK_CYCLES(Blank)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(sif)
  );

  always #5 clk = ~clk;

  // Cycles since reset release; cycle 0 is the first cycle with rst low.
  always @(posedge clk) t <= rst ? 0 : t + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0d: got %0d, expected %0d", name, t, got, exp);
    end
  endtask

  task automatic drive_at(input int k);
    while (t < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_cyc(input int k);
    do @(negedge clk); while (t < k);
  endtask

  // Slot-level model: position within the current slot and the frame's latched bitmap.
  logic [Leds-1:0] m_buf;
  int   m_idx = 0, m_pos = 0;
  logic exp_en = 1'b0, exp_fd = 1'b0, m_valid = 1'b0;

  function automatic int slot_len(input logic [Leds-1:0] b, input int idx);
    return (SkipMode && !b[idx]) ? 1 : Slot;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        check("led_index", 32'(sif.led_index), 32'(m_idx));
        check("led_enable", 32'(sif.led_enable), 32'(exp_en));
        check("frame_done", 32'(sif.frame_done), 32'(exp_fd));
      end
      if (rst) begin
        m_valid = 1'b1;
        m_idx   = 0;
        m_pos   = 0;
        exp_en  = 1'b0;
        exp_fd  = 1'b0;
        m_buf   = sif.leds;
      end else if (m_valid) begin
        if (m_pos == slot_len(m_buf, m_idx) - 1) begin
          m_pos  = 0;
          exp_en = 1'b0;
          if (m_idx == Leds - 1) begin
            m_idx  = 0;
            m_buf  = sif.leds;
            exp_fd = 1'b1;
          end else begin
            m_idx++;
            exp_fd = 1'b0;
          end
        end else begin
          m_pos++;
          exp_fd = 1'b0;
          exp_en = (m_pos >= Blank) && m_buf[m_idx] && sif.enable;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  int high_cnt;

  initial begin
    sif.leds   = 6'b000001;
    sif.enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single lit LED, then tear-free update.
    at_cyc(0);
    check("rst_idx", 32'(sif.led_index), 0);
    check("rst_en", 32'(sif.led_enable), 0);
    check("rst_fd", 32'(sif.frame_done), 0);
    at_cyc(1);  check("blank1_en", 32'(sif.led_enable), 0);
    at_cyc(2);  check("on0_en", 32'(sif.led_enable), 1);
    at_cyc(5);  check("on3_en", 32'(sif.led_enable), 1);
`ifndef CHARLIEPLEX_SKIP_DARK_EN
    at_cyc(6);  check("idx1_idx", 32'(sif.led_index), 1);
    check("idx1_en", 32'(sif.led_enable), 0);
    at_cyc(35); check("idx5_idx", 32'(sif.led_index), 5);
    check("pre_wrap_fd", 32'(sif.frame_done), 0);
    at_cyc(36); check("wrap_fd", 32'(sif.frame_done), 1);
    check("wrap_idx", 32'(sif.led_index), 0);
    at_cyc(37); check("wrap_fd_clear", 32'(sif.frame_done), 0);
    at_cyc(38); check("frame2_on", 32'(sif.led_enable), 1);
`endif
    drive_at(46);
    sif.leds = 6'b100000;
`ifndef CHARLIEPLEX_SKIP_DARK_EN
    at_cyc(68);  check("tear_idx5_dark", 32'(sif.led_enable), 0);
    at_cyc(74);  check("next_idx0_dark", 32'(sif.led_enable), 0);
    at_cyc(104); check("next_idx5_on", 32'(sif.led_enable), 1);
    check("next_idx5_idx", 32'(sif.led_index), 5);
    at_cyc(107); check("next_idx5_last", 32'(sif.led_enable), 1);
`endif

    // Global enable low with all LEDs requested, then raised mid-dwell.
    drive_at(110);
    sif.leds   = 6'b111111;
    sif.enable = 1'b0;
`ifndef CHARLIEPLEX_SKIP_DARK_EN
    at_cyc(146); check("gate_en", 32'(sif.led_enable), 0);
    at_cyc(150); check("gate_step_idx", 32'(sif.led_index), 1);
`endif
    drive_at(183);
    sif.enable = 1'b1;
`ifndef CHARLIEPLEX_SKIP_DARK_EN
    at_cyc(183); check("raise_same", 32'(sif.led_enable), 0);
    at_cyc(184); check("raise_next", 32'(sif.led_enable), 1);
    at_cyc(185); check("raise_hold", 32'(sif.led_enable), 1);
    at_cyc(186); check("raise_end", 32'(sif.led_enable), 0);
    check("raise_end_idx", 32'(sif.led_index), 1);
`endif

    // All lit: 24 enabled cycles per 36-cycle frame.
    at_cyc(215);
    high_cnt = 0;
    for (int i = 0; i < 36; i++) begin
      at_cyc(216 + i);
      high_cnt += int'(sif.led_enable);
    end
    check("all_lit_high_cycles", 32'(high_cnt), 24);

    // Reset during the ON phase of index 3.
    drive_at(273);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    at_cyc(0);
    check("midrst_idx", 32'(sif.led_index), 0);
    check("midrst_en", 32'(sif.led_enable), 0);
    check("midrst_fd", 32'(sif.frame_done), 0);
    at_cyc(1); check("midrst_blank", 32'(sif.led_enable), 0);
    at_cyc(2); check("midrst_on", 32'(sif.led_enable), 1);
    check("midrst_on_idx", 32'(sif.led_index), 0);

    // Sparse bitmap; dark slots collapse when skipping is built in.
    drive_at(20);
    sif.leds = 6'b000101;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
`ifdef CHARLIEPLEX_SKIP_DARK_EN
    at_cyc(2);  check("skip_idx0_on", 32'(sif.led_enable), 1);
    at_cyc(6);  check("skip_idx1", 32'(sif.led_index), 1);
    check("skip_idx1_en", 32'(sif.led_enable), 0);
    at_cyc(7);  check("skip_idx2", 32'(sif.led_index), 2);
    at_cyc(9);  check("skip_idx2_on", 32'(sif.led_enable), 1);
    at_cyc(12); check("skip_idx2_last", 32'(sif.led_enable), 1);
    at_cyc(15); check("skip_idx5", 32'(sif.led_index), 5);
    at_cyc(16); check("skip_wrap_fd", 32'(sif.frame_done), 1);
    at_cyc(32); check("skip_wrap2_fd", 32'(sif.frame_done), 1);
`else
    at_cyc(14); check("sparse_idx2_on", 32'(sif.led_enable), 1);
    check("sparse_idx2_idx", 32'(sif.led_index), 2);
    at_cyc(20); check("sparse_idx3_dark", 32'(sif.led_enable), 0);
    at_cyc(36); check("sparse_wrap_fd", 32'(sif.frame_done), 1);
`endif
    at_cyc(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
